// File: rtl/vs_codec_responder.sv
// rtl/vs_codec_responder.sv - SCI/SDI responder model of a VS10xx-style audio decoder
//
// Purpose: decodes SCI command frames (XCS) and SDI stream bytes (XDCS) from
// the MP3 driver. Holds the 16 SCI registers and buffers stream bytes in a FIFO
// that drains at a fixed rate. Generates DREQ flow control from the FIFO free
// space and the boot, soft-reset and SCI-busy counters.
//
// Optional feature macro: VSR_SCI_READ_EN
//   defined   : opcode 0x03 (SCI read) shifts the addressed register out on o_SO
//   undefined : o_SO tied low, opcode 0x03 rejected like any unknown opcode
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   i_XRST                chip hardware reset from driver, active low
//   i_XCS / i_XDCS        SCI / SDI chip selects, active low (XCS wins)
//   i_SCK, i_SI           serial clock (async to clk) and data, MSB first
//   o_SO                  serial data out for SCI reads
//   o_DREQ                ready for more SDI data
//   o_mode, o_vol         SCI registers 0x0 and 0xB
//   o_byte, o_byte_valid  drained FIFO byte and its one-clk strobe
//   o_level               FIFO occupancy
//   o_cmd_err             one-clk pulse on bad opcode or address
//   o_overflow            sticky flag: SDI byte dropped on full FIFO
module vs_codec_responder #(
  parameter int FIFO_DEPTH      = 64,
  parameter int DREQ_THRESH     = 32,
  parameter int DRAIN_DIV       = 16,
  parameter int BOOT_CYCLES     = 1000,
  parameter int SOFTRST_CYCLES  = 200,
  parameter int SCI_BUSY_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_XRST,
  input  logic                        i_XCS,
  input  logic                        i_XDCS,
  input  logic                        i_SCK,
  input  logic                        i_SI,
  output logic                        o_SO,
  output logic                        o_DREQ,
  output logic [15:0]                 o_mode,
  output logic [15:0]                 o_vol,
  output logic [7:0]                  o_byte,
  output logic                        o_byte_valid,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_cmd_err,
  output logic                        o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam int BW = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam int SW = (SOFTRST_CYCLES > 0) ? $clog2(SOFTRST_CYCLES + 1) : 1;
  localparam int CW = (SCI_BUSY_CYCLES > 0) ? $clog2(SCI_BUSY_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SCI_OP,
    SCI_ADDR,
    SCI_DATA,
    SDI_BYTE
  } link_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and SCK edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] xcs_ff, xdcs_ff, sck_ff, si_ff, xrst_ff;
  logic       sck_d;
  logic       xcs_s, xdcs_s, si_s, xrst_s, sck_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xcs_ff  <= 2'b11;
      xdcs_ff <= 2'b11;
      sck_ff  <= 2'b00;
      si_ff   <= 2'b00;
      xrst_ff <= 2'b00;
      sck_d   <= 1'b0;
    end else begin
      xcs_ff  <= {xcs_ff[0], i_XCS};
      xdcs_ff <= {xdcs_ff[0], i_XDCS};
      sck_ff  <= {sck_ff[0], i_SCK};
      si_ff   <= {si_ff[0], i_SI};
      xrst_ff <= {xrst_ff[0], i_XRST};
      sck_d   <= sck_ff[1];
    end
  end

  assign xcs_s    = xcs_ff[1];
  assign xdcs_s   = xdcs_ff[1];
  assign si_s     = si_ff[1];
  assign xrst_s   = xrst_ff[1];
  assign sck_rise = sck_ff[1] & ~sck_d;

  // ---------------------------------------------------------------------------
  // Link FSM
  // ---------------------------------------------------------------------------
  link_state_t state, state_next;
  logic [4:0]  bit_cnt;
  logic [14:0] sr;
  logic [7:0]  shift_in;
  logic [15:0] data16;
  logic        sci_drop, op_write, addr_bad_q, op_valid;
  logic [3:0]  addr_q;
  logic        push_req, commit, op_done, addr_done, bad_op, bad_addr;

  // The bit being sampled this cycle completes the byte / word in flight.
  assign shift_in = {sr[6:0], si_s};
  assign data16   = {sr, si_s};

`ifdef VSR_SCI_READ_EN
  assign op_valid = (shift_in == 8'h02) || (shift_in == 8'h03);
`else
  assign op_valid = (shift_in == 8'h02);
`endif

  always_comb begin
    state_next = state;
    push_req   = 1'b0;
    commit     = 1'b0;
    op_done    = 1'b0;
    addr_done  = 1'b0;
    bad_op     = 1'b0;
    bad_addr   = 1'b0;
    case (state)
      IDLE: begin
        if (!xcs_s)       state_next = SCI_OP;
        else if (!xdcs_s) state_next = SDI_BYTE;
      end
      SCI_OP: begin
        if (xcs_s) begin
          state_next = IDLE;
        end else if (sck_rise && !sci_drop && bit_cnt == 5'd7) begin
          op_done = 1'b1;
          if (op_valid) state_next = SCI_ADDR;
          else          bad_op     = 1'b1;
        end
      end
      SCI_ADDR: begin
        if (xcs_s) begin
          state_next = IDLE;
        end else if (sck_rise && bit_cnt == 5'd15) begin
          addr_done  = 1'b1;
          bad_addr   = |shift_in[7:4];
          state_next = SCI_DATA;
        end
      end
      SCI_DATA: begin
        if (xcs_s) begin
          state_next = IDLE;
        end else if (sck_rise && bit_cnt == 5'd31) begin
          commit     = op_write && !addr_bad_q;
          state_next = IDLE;
        end
      end
      SDI_BYTE: begin
        // XCS takes over mid-byte; the partial SDI byte is simply dropped.
        if (!xcs_s)      state_next = SCI_OP;
        else if (xdcs_s) state_next = IDLE;
        else if (sck_rise && bit_cnt[2:0] == 3'd7) push_req = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 5'd0;
      sr         <= 15'd0;
      sci_drop   <= 1'b0;
      op_write   <= 1'b0;
      addr_q     <= 4'd0;
      addr_bad_q <= 1'b0;
      o_cmd_err  <= 1'b0;
    end else if (!xrst_s) begin
      state      <= IDLE;
      bit_cnt    <= 5'd0;
      sr         <= 15'd0;
      sci_drop   <= 1'b0;
      op_write   <= 1'b0;
      addr_q     <= 4'd0;
      addr_bad_q <= 1'b0;
      o_cmd_err  <= 1'b0;
    end else begin
      state     <= state_next;
      o_cmd_err <= bad_op | bad_addr;
      if (state_next == IDLE || state == IDLE ||
          (state == SDI_BYTE && state_next == SCI_OP))
        bit_cnt <= 5'd0;
      else if (sck_rise)
        bit_cnt <= bit_cnt + 5'd1;
      if (sck_rise) sr <= {sr[13:0], si_s};
      if (state_next == IDLE) sci_drop <= 1'b0;
      else if (bad_op)        sci_drop <= 1'b1;
      if (op_done) op_write <= (shift_in == 8'h02);
      if (addr_done) begin
        addr_q     <= shift_in[3:0];
        addr_bad_q <= bad_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SCI register file
  // ---------------------------------------------------------------------------
  logic [15:0] regs [16];
  logic        soft_rst;

  assign soft_rst = commit && (addr_q == 4'd0) && data16[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= (i == 0) ? 16'h0800 : 16'h0000;
    end else if (!xrst_s) begin
      for (int i = 0; i < 16; i++) regs[i] <= (i == 0) ? 16'h0800 : 16'h0000;
    end else if (commit) begin
      // MODE bit 2 is a self-clearing soft-reset request.
      if (addr_q == 4'd0) regs[0]      <= data16 & ~16'h0004;
      else                regs[addr_q] <= data16;
    end
  end

  assign o_mode = regs[0];
  assign o_vol  = regs[4'hB];

`ifdef VSR_SCI_READ_EN
  logic [15:0] rd_sr;
  logic        so_q;
  logic        sck_fall;

  assign sck_fall = ~sck_ff[1] & sck_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sr <= 16'd0;
      so_q  <= 1'b0;
    end else if (!xrst_s || state == IDLE) begin
      rd_sr <= 16'd0;
      so_q  <= 1'b0;
    end else if (addr_done && shift_in != 8'h00 && !op_write) begin
      rd_sr <= bad_addr ? 16'd0 : regs[shift_in[3:0]];
    end else if (addr_done && !op_write) begin
      rd_sr <= regs[0];
    end else if (state == SCI_DATA && !op_write && sck_fall) begin
      so_q  <= rd_sr[15];
      rd_sr <= {rd_sr[14:0], 1'b0};
    end
  end

  assign o_SO = so_q;
`else
  assign o_SO = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Busy counters (saturate at zero)
  // ---------------------------------------------------------------------------
  logic [BW-1:0] boot_cnt;
  logic [SW-1:0] soft_cnt;
  logic [CW-1:0] sci_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_cnt <= BW'(BOOT_CYCLES);
      soft_cnt <= '0;
      sci_cnt  <= '0;
    end else if (!xrst_s) begin
      boot_cnt <= BW'(BOOT_CYCLES);
      soft_cnt <= '0;
      sci_cnt  <= '0;
    end else begin
      if (boot_cnt != '0) boot_cnt <= boot_cnt - BW'(1);
      if (soft_rst)           soft_cnt <= SW'(SOFTRST_CYCLES);
      else if (soft_cnt != '0) soft_cnt <= soft_cnt - SW'(1);
      if (commit)             sci_cnt <= CW'(SCI_BUSY_CYCLES);
      else if (sci_cnt != '0) sci_cnt <= sci_cnt - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // SDI FIFO and fixed-rate drain
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [DW-1:0] div_cnt;
  logic          full, flush, push_ok, pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign flush   = soft_rst;
  assign push_ok = push_req && !full && !flush;
  // Drain divider only runs while data is queued, so the first byte leaves
  // a full DRAIN_DIV period after it arrived.
  assign pop     = (level != '0) && (div_cnt == DW'(DRAIN_DIV - 1)) && !flush;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      div_cnt      <= '0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
      o_overflow   <= 1'b0;
    end else if (!xrst_s) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      div_cnt      <= '0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_byte_valid <= pop;
      if (push_req && full) o_overflow <= 1'b1;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level   <= '0;
        div_cnt <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          o_byte <= mem[rd_ptr];
        end
        case ({push_ok, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
        if (level == '0 || pop) div_cnt <= '0;
        else                    div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  assign o_level = level;
  assign o_DREQ  = xrst_s && (boot_cnt == '0) && (soft_cnt == '0) && (sci_cnt == '0) &&
                   ((LW'(FIFO_DEPTH) - level) >= LW'(DREQ_THRESH));

endmodule

// File: tb/tb_vs_codec_responder.sv
// tb/tb_vs_codec_responder.sv - directed self-checking bench for vs_codec_responder
module tb_vs_codec_responder;

  localparam int TB_DRAIN = 8192;
  localparam int TB_BOOT  = 1000;
  localparam int H        = 5;

  logic        clk = 1'b0;
  logic        rst_n, i_XRST, i_XCS, i_XDCS, i_SCK, i_SI;
  logic        o_SO, o_DREQ, o_byte_valid, o_cmd_err, o_overflow;
  logic [15:0] o_mode, o_vol;
  logic [7:0]  o_byte;
  logic [6:0]  o_level;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int err_pulses = 0;
  int n_str = 0;
  logic [7:0] str_byte [64];
  int         str_cyc  [64];

  vs_codec_responder #(
    .FIFO_DEPTH(64), .DREQ_THRESH(32), .DRAIN_DIV(TB_DRAIN),
    .BOOT_CYCLES(TB_BOOT), .SOFTRST_CYCLES(200), .SCI_BUSY_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_XRST(i_XRST), .i_XCS(i_XCS), .i_XDCS(i_XDCS),
    .i_SCK(i_SCK), .i_SI(i_SI), .o_SO(o_SO), .o_DREQ(o_DREQ), .o_mode(o_mode),
    .o_vol(o_vol), .o_byte(o_byte), .o_byte_valid(o_byte_valid), .o_level(o_level),
    .o_cmd_err(o_cmd_err), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_cmd_err === 1'b1) err_pulses = err_pulses + 1;
    if (o_byte_valid === 1'b1 && n_str < 64) begin
      str_byte[n_str] = o_byte;
      str_cyc[n_str]  = cyc;
      n_str = n_str + 1;
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic s);
    i_SI = b;
    clk_wait(H);
    i_SCK = 1'b1;
    s = o_SO;
    clk_wait(H);
    i_SCK = 1'b0;
  endtask

  task automatic sci_frame(input logic [31:0] w, input int nbits,
                           output logic [15:0] rd, output logic dreq_end);
    logic s;
    rd = 16'h0000;
    i_XCS = 1'b0;
    clk_wait(H);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(w[31-i], s);
      if (i >= 16) rd[31-i] = s;
    end
    dreq_end = o_DREQ;
    clk_wait(2);
    i_XCS = 1'b1;
    clk_wait(3 * H);
  endtask

  task automatic sdi_byte(input logic [7:0] b);
    logic s;
    i_XDCS = 1'b0;
    clk_wait(2);
    for (int i = 0; i < 8; i++) spi_bit(b[7-i], s);
    clk_wait(2);
    i_XDCS = 1'b1;
    clk_wait(4);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_XRST = 1'b0; i_XCS = 1'b1; i_XDCS = 1'b1; i_SCK = 1'b0; i_SI = 1'b0;
    clk_wait(4);
    total++; if (o_DREQ !== 1'b0) $display("FAIL rst_dreq: got %b want 0", o_DREQ); else passed++;
    total++; if (o_SO !== 1'b0) $display("FAIL rst_so: got %b want 0", o_SO); else passed++;
    total++; if (o_mode !== 16'h0800) $display("FAIL rst_mode: got %h want 0800", o_mode); else passed++;
    total++; if (o_vol !== 16'h0000) $display("FAIL rst_vol: got %h want 0000", o_vol); else passed++;
    total++; if (o_byte !== 8'h00 || o_byte_valid !== 1'b0)
      $display("FAIL rst_byte: got %h/%b want 00/0", o_byte, o_byte_valid); else passed++;
    total++; if (o_level !== 7'd0) $display("FAIL rst_level: got %0d want 0", o_level); else passed++;
    total++; if (o_cmd_err !== 1'b0 || o_overflow !== 1'b0)
      $display("FAIL rst_flags: got err %b ovf %b want 0 0", o_cmd_err, o_overflow); else passed++;
    rst_n = 1'b1;
    clk_wait(2);
  endtask

  task automatic test_boot;
    int waited;
    clk_wait(20);
    total++; if (o_DREQ !== 1'b0) $display("FAIL xrst_dreq: got %b want 0", o_DREQ); else passed++;
    i_XRST = 1'b1;
    clk_wait(TB_BOOT - 10);
    total++; if (o_DREQ !== 1'b0) $display("FAIL boot_hold: got %b want 0", o_DREQ); else passed++;
    waited = 0;
    while (o_DREQ !== 1'b1 && waited < 40) begin clk_wait(1); waited++; end
    total++; if (o_DREQ !== 1'b1) $display("FAIL boot_release: got %b want 1", o_DREQ); else passed++;
    total++; if (o_level !== 7'd0) $display("FAIL boot_level: got %0d want 0", o_level); else passed++;
  endtask

  task automatic test_sci_write;
    logic [15:0] rd;
    logic de;
    int waited;
    sci_frame(32'h02000804, 32, rd, de);
    total++; if (o_mode !== 16'h0800) $display("FAIL mode_bit2_clear: got %h want 0800", o_mode); else passed++;
    clk_wait(150);
    total++; if (o_DREQ !== 1'b0) $display("FAIL softrst_hold: got %b want 0", o_DREQ); else passed++;
    waited = 0;
    while (o_DREQ !== 1'b1 && waited < 100) begin clk_wait(1); waited++; end
    total++; if (o_DREQ !== 1'b1) $display("FAIL softrst_release: got %b want 1", o_DREQ); else passed++;
    sci_frame(32'h020B0000, 32, rd, de);
    total++; if (o_vol !== 16'h0000) $display("FAIL vol_zero: got %h want 0000", o_vol); else passed++;
    sci_frame(32'h020B2020, 32, rd, de);
    total++; if (de !== 1'b0) $display("FAIL sci_busy_dreq: got %b want 0", de); else passed++;
    total++; if (o_vol !== 16'h2020) $display("FAIL vol_2020: got %h want 2020", o_vol); else passed++;
    total++; if (o_DREQ !== 1'b1) $display("FAIL sci_busy_release: got %b want 1", o_DREQ); else passed++;
  endtask

  task automatic test_abort;
    logic [15:0] rd;
    logic de;
    sci_frame(32'h020B5555, 20, rd, de);
    total++; if (o_vol !== 16'h2020) $display("FAIL abort_no_commit: got %h want 2020", o_vol); else passed++;
    sci_frame(32'h020B1234, 32, rd, de);
    total++; if (o_vol !== 16'h1234) $display("FAIL after_abort_write: got %h want 1234", o_vol); else passed++;
    sci_frame(32'h020B2020, 32, rd, de);
  endtask

  task automatic test_cmd_err;
    logic [15:0] rd;
    logic de;
    int e0;
    e0 = err_pulses;
    sci_frame(32'h07000000, 32, rd, de);
    total++; if (err_pulses - e0 !== 1) $display("FAIL bad_opcode_pulse: got %0d pulses want 1", err_pulses - e0); else passed++;
    total++; if (o_mode !== 16'h0800) $display("FAIL bad_opcode_mode: got %h want 0800", o_mode); else passed++;
    e0 = err_pulses;
    sci_frame(32'h02FB1111, 32, rd, de);
    total++; if (err_pulses - e0 !== 1) $display("FAIL bad_addr_pulse: got %0d pulses want 1", err_pulses - e0); else passed++;
    total++; if (o_vol !== 16'h2020) $display("FAIL bad_addr_discard: got %h want 2020", o_vol); else passed++;
    e0 = err_pulses;
    sci_frame(32'h030B0000, 32, rd, de);
`ifdef VSR_SCI_READ_EN
    total++; if (rd !== 16'h2020) $display("FAIL sci_read_data: got %h want 2020", rd); else passed++;
    total++; if (err_pulses - e0 !== 0) $display("FAIL sci_read_err: got %0d pulses want 0", err_pulses - e0); else passed++;
`else
    total++; if (err_pulses - e0 !== 1) $display("FAIL read_disabled_err: got %0d pulses want 1", err_pulses - e0); else passed++;
`endif
    total++; if (o_vol !== 16'h2020) $display("FAIL read_keeps_vol: got %h want 2020", o_vol); else passed++;
  endtask

  task automatic test_overflow;
    total++; if (o_DREQ !== 1'b1) $display("FAIL fill_start_dreq: got %b want 1", o_DREQ); else passed++;
    for (int n = 1; n <= 65; n++) begin
      sdi_byte(n[0] ? 8'hA5 : 8'h5A);
      if (n == 32) begin
        total++; if (o_level !== 7'd32 || o_DREQ !== 1'b1)
          $display("FAIL fill_32: got level %0d dreq %b want 32 1", o_level, o_DREQ); else passed++;
      end
      if (n == 33) begin
        total++; if (o_level !== 7'd33 || o_DREQ !== 1'b0)
          $display("FAIL fill_33: got level %0d dreq %b want 33 0", o_level, o_DREQ); else passed++;
      end
      if (n == 64) begin
        total++; if (o_level !== 7'd64 || o_overflow !== 1'b0)
          $display("FAIL fill_64: got level %0d ovf %b want 64 0", o_level, o_overflow); else passed++;
      end
      if (n == 65) begin
        total++; if (o_level !== 7'd64 || o_overflow !== 1'b1)
          $display("FAIL fill_65: got level %0d ovf %b want 64 1", o_level, o_overflow); else passed++;
      end
    end
  endtask

  task automatic test_flush;
    logic [15:0] rd;
    logic de;
    sci_frame(32'h02000804, 32, rd, de);
    total++; if (o_level !== 7'd0) $display("FAIL flush_level: got %0d want 0", o_level); else passed++;
    total++; if (o_overflow !== 1'b1) $display("FAIL overflow_sticky: got %b want 1", o_overflow); else passed++;
    total++; if (o_mode !== 16'h0800) $display("FAIL flush_mode: got %h want 0800", o_mode); else passed++;
  endtask

  task automatic test_back_to_back;
    int base;
    int waited;
    base = n_str;
    sdi_byte(8'h12);
    sdi_byte(8'h34);
    total++; if (o_level !== 7'd2) $display("FAIL drain_queued: got %0d want 2", o_level); else passed++;
    waited = 0;
    while (n_str < base + 2 && waited < 3 * TB_DRAIN) begin clk_wait(1); waited++; end
    total++; if (n_str - base !== 2) $display("FAIL drain_count: got %0d want 2", n_str - base); else passed++;
    total++; if (str_byte[base] !== 8'h12) $display("FAIL drain_first: got %h want 12", str_byte[base]); else passed++;
    total++; if (str_byte[base+1] !== 8'h34) $display("FAIL drain_second: got %h want 34", str_byte[base+1]); else passed++;
    total++; if (str_cyc[base+1] - str_cyc[base] !== TB_DRAIN)
      $display("FAIL drain_spacing: got %0d want %0d", str_cyc[base+1] - str_cyc[base], TB_DRAIN); else passed++;
    clk_wait(2);
    total++; if (o_level !== 7'd0) $display("FAIL drain_empty: got %0d want 0", o_level); else passed++;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_sci_write();
    test_abort();
    test_cmd_err();
    test_overflow();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
